// File: rtl/fixed_point_mult_arbiter_if.sv
// Handshake bundle between the arbiter, its requesters and the shared multiplier.
// The master modport is the environment side; the slave modport is the arbiter side.
interface fixed_point_mult_arbiter_if #(
    parameter int n    = 32,
    parameter int NREQ = 4
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_val;
    logic [NREQ-1:0]   req_rdy;
    logic [NREQ*n-1:0] req_a;
    logic [NREQ*n-1:0] req_b;
    logic [NREQ-1:0]   resp_val;
    logic [NREQ-1:0]   resp_rdy;
    logic [n-1:0]      resp_c;
    logic              mul_recv_val;
    logic              mul_recv_rdy;
    logic [n-1:0]      mul_a;
    logic [n-1:0]      mul_b;
    logic              mul_send_val;
    logic              mul_send_rdy;
    logic [n-1:0]      mul_c;
    logic [GW-1:0]     grant_id;
    logic              busy;

    modport master (
        output req_val, req_a, req_b, resp_rdy, mul_recv_rdy, mul_send_val, mul_c,
        input  req_rdy, resp_val, resp_c, mul_recv_val, mul_a, mul_b, mul_send_rdy,
               grant_id, busy
    );

    modport slave (
        input  req_val, req_a, req_b, resp_rdy, mul_recv_rdy, mul_send_val, mul_c,
        output req_rdy, resp_val, resp_c, mul_recv_val, mul_a, mul_b, mul_send_rdy,
               grant_id, busy
    );
endinterface

// File: rtl/fixed_point_mult_arbiter.sv
// Round-robin arbiter sharing one fixed-point multiplier among NREQ requesters,
// one transaction in flight; adds one cycle before issue and one after the result.
module fixed_point_mult_arbiter #(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter int NREQ = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    fixed_point_mult_arbiter_if.slave  bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (d < 0 || d > n || NREQ < 1 || NREQ > 8) begin : g_bad_params
        $error("fixed_point_mult_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q;
    logic [GW-1:0] rr_ptr_q;
    logic [GW-1:0] gid_q;
    logic [n-1:0]  a_q;
    logic [n-1:0]  b_q;
    logic [n-1:0]  c_q;

    logic            win_vld;
    logic [GW-1:0]   win_id;
    logic [GW-1:0]   nxt_ptr;
    logic [n-1:0]    win_a;
    logic [n-1:0]    win_b;
    logic [NREQ-1:0] win_oh;
    logic [NREQ-1:0] owner_oh;

    // Descending search so the candidate closest to rr_ptr is assigned last and wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_val[i] && ((int'(rr_ptr_q) + k) % NREQ) == i) begin
                    win_vld = 1'b1;
                    win_id  = GW'(i);
                end
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == GW'(i)) begin
                win_a = bus.req_a[i*n +: n];
                win_b = bus.req_b[i*n +: n];
            end
        end
    end

    assign nxt_ptr  = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
    assign win_oh   = NREQ'(1) << win_id;
    assign owner_oh = NREQ'(1) << gid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gid_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        a_q      <= win_a;
                        b_q      <= win_b;
                        gid_q    <= win_id;
                        rr_ptr_q <= nxt_ptr;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mul_recv_rdy) state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.mul_send_val) begin
                        c_q     <= bus.mul_c;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (|(bus.resp_rdy & owner_oh)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // req_rdy is the only output fed combinationally from inputs, so it alone needs the reset gate.
    assign bus.req_rdy      = (reset_n && state_q == IDLE && win_vld) ? win_oh : '0;
    assign bus.resp_val     = (state_q == RESP) ? owner_oh : '0;
    assign bus.resp_c       = c_q;
    assign bus.mul_recv_val = (state_q == ISSUE);
    assign bus.mul_send_rdy = (state_q == WAIT);
    assign bus.mul_a        = a_q;
    assign bus.mul_b        = b_q;
    assign bus.grant_id     = gid_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_fixed_point_mult_arbiter.sv
// Directed bench for fixed_point_mult_arbiter; the bench plays the multiplier with precomputed products.
module tb_fixed_point_mult_arbiter;
    localparam int N  = 32;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   errs   = 0;
    int   checks = 0;

    logic [3:0]  exp_oh  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0]  exp_gid [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] exp_a   [6] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 32'hA1};

    fixed_point_mult_arbiter_if #(.n(N), .NREQ(NR)) bus();

    fixed_point_mult_arbiter #(.n(N), .d(16), .NREQ(NR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_rdy"},  32'(bus.req_rdy),      32'h0);
        chk({tag, "_resp_val"}, 32'(bus.resp_val),     32'h0);
        chk({tag, "_resp_c"},   bus.resp_c,            32'h0);
        chk({tag, "_recv_val"}, 32'(bus.mul_recv_val), 32'h0);
        chk({tag, "_send_rdy"}, 32'(bus.mul_send_rdy), 32'h0);
        chk({tag, "_mul_a"},    bus.mul_a,             32'h0);
        chk({tag, "_mul_b"},    bus.mul_b,             32'h0);
        chk({tag, "_grant_id"}, 32'(bus.grant_id),     32'h0);
        chk({tag, "_busy"},     32'(bus.busy),         32'h0);
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.req_val      = '0;
        bus.req_a        = '0;
        bus.req_b        = '0;
        bus.resp_rdy     = '0;
        bus.mul_recv_rdy = 1'b0;
        bus.mul_send_val = 1'b0;
        bus.mul_c        = '0;
        tick();
        tick();
        bus.req_val = 4'hF;
        #1;
        chk_all_zero("reset");

        // All four requesters valid from reset: strict rotation 0,1,2,3,0,1
        bus.req_a[0+:32]  = 32'hA0; bus.req_a[32+:32] = 32'hA1;
        bus.req_a[64+:32] = 32'hA2; bus.req_a[96+:32] = 32'hA3;
        bus.req_b[0+:32]  = 32'hB0; bus.req_b[32+:32] = 32'hB1;
        bus.req_b[64+:32] = 32'hB2; bus.req_b[96+:32] = 32'hB3;
        bus.resp_rdy     = 4'hF;
        bus.mul_recv_rdy = 1'b1;
        bus.mul_send_val = 1'b1;
        bus.mul_c        = 32'h0000_5555;
        tick();
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            for (int g = 0; g < 10 && bus.req_rdy == '0; g++) tick();
            chk("rr_req_rdy", 32'(bus.req_rdy), 32'(exp_oh[i]));
            tick();
            chk("rr_grant_id", 32'(bus.grant_id), 32'(exp_gid[i]));
            chk("rr_mul_a", bus.mul_a, exp_a[i]);
            chk("rr_recv_val", 32'(bus.mul_recv_val), 32'h1);
            for (int g = 0; g < 10 && bus.resp_val == '0; g++) tick();
            chk("rr_resp_val", 32'(bus.resp_val), 32'(exp_oh[i]));
            chk("rr_resp_c", bus.resp_c, 32'h0000_5555);
        end
        bus.req_val = '0;
        tick();
        chk("rr_drain_busy", 32'(bus.busy), 32'h0);

        // Requester 2, unsigned 2.0 * 1.5; multiplier stalls recv_rdy
        bus.mul_recv_rdy = 1'b0;
        bus.mul_send_val = 1'b0;
        bus.resp_rdy     = '0;
        bus.req_a[64+:32] = 32'h0002_0000;
        bus.req_b[64+:32] = 32'h0001_8000;
        bus.req_val = 4'b0100;
        #1;
        chk("u_req_rdy", 32'(bus.req_rdy), 32'h4);
        tick();
        bus.req_val = '0;
        chk("u_issue_val", 32'(bus.mul_recv_val), 32'h1);
        chk("u_mul_a", bus.mul_a, 32'h0002_0000);
        chk("u_mul_b", bus.mul_b, 32'h0001_8000);
        chk("u_grant_id", 32'(bus.grant_id), 32'h2);
        chk("u_busy", 32'(bus.busy), 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_recv_val", 32'(bus.mul_recv_val), 32'h1);
            chk("stall_mul_a", bus.mul_a, 32'h0002_0000);
            chk("stall_mul_b", bus.mul_b, 32'h0001_8000);
        end
        bus.mul_recv_rdy = 1'b1;
        tick();
        chk("u_wait_send_rdy", 32'(bus.mul_send_rdy), 32'h1);
        chk("u_wait_recv_val", 32'(bus.mul_recv_val), 32'h0);
        bus.mul_send_val = 1'b1;
        bus.mul_c        = 32'h0003_0000;
        tick();
        bus.mul_send_val = 1'b0;
        bus.mul_c        = 32'hDEAD_BEEF;
        chk("u_resp_val", 32'(bus.resp_val), 32'h4);
        chk("u_resp_c", bus.resp_c, 32'h0003_0000);
        chk("u_resp_send_rdy", 32'(bus.mul_send_rdy), 32'h0);
        bus.resp_rdy = 4'b1011;
        tick();
        chk("nonowner_rdy_ignored", 32'(bus.resp_val), 32'h4);
        bus.resp_rdy = 4'b0100;
        tick();
        bus.resp_rdy = '0;
        chk("u_done_resp_val", 32'(bus.resp_val), 32'h0);
        chk("u_done_busy", 32'(bus.busy), 32'h0);

        // Requester 1 owns the multiplier while requester 3 waits behind RESP backpressure
        bus.req_a[32+:32] = 32'h0000_1111;
        bus.req_a[96+:32] = 32'h0000_3333;
        bus.req_val = 4'b0010;
        #1;
        chk("bp_req_rdy1", 32'(bus.req_rdy), 32'h2);
        tick();
        bus.req_val      = 4'b1010;
        bus.mul_send_val = 1'b1;
        bus.mul_c        = 32'h1234_5678;
        tick();
        tick();
        bus.mul_send_val = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_resp_val", 32'(bus.resp_val), 32'h2);
            chk("bp_resp_c", bus.resp_c, 32'h1234_5678);
            chk("bp_req_rdy_held", 32'(bus.req_rdy), 32'h0);
            tick();
        end
        bus.resp_rdy = 4'b0010;
        tick();
        bus.resp_rdy = '0;
        chk("bp_first_idle_req_rdy", 32'(bus.req_rdy), 32'h8);
        tick();
        bus.req_val = '0;
        chk("bp_grant_id3", 32'(bus.grant_id), 32'h3);
        chk("bp_mul_a3", bus.mul_a, 32'h0000_3333);
        bus.mul_send_val = 1'b1;
        tick();
        tick();
        bus.mul_send_val = 1'b0;
        chk("bp_resp_val3", 32'(bus.resp_val), 32'h8);
        bus.resp_rdy = 4'b1000;
        tick();
        bus.resp_rdy = '0;

        // Reset while requester 0 is in WAIT: dropped op, pointer restarts at 0
        bus.req_a[0+:32] = 32'h0000_7777;
        bus.req_val = 4'b0001;
        tick();
        bus.req_val = '0;
        tick();
        chk("rw_in_wait", 32'(bus.mul_send_rdy), 32'h1);
        reset_n = 1'b0;
        tick();
        bus.req_val = 4'b1001;
        #1;
        chk_all_zero("rw");
        reset_n = 1'b1;
        bus.req_a[0+:32] = 32'hFFFF_0000;
        bus.req_b[0+:32] = 32'h0002_0000;
        #1;
        chk("rw_restart_req_rdy", 32'(bus.req_rdy), 32'h1);
        chk("rw_no_resp", 32'(bus.resp_val), 32'h0);
        tick();
        bus.req_val = '0;
        chk("s_grant_id", 32'(bus.grant_id), 32'h0);
        chk("s_mul_a", bus.mul_a, 32'hFFFF_0000);
        chk("s_mul_b", bus.mul_b, 32'h0002_0000);
        bus.mul_send_val = 1'b1;
        bus.mul_c        = 32'hFFFE_0000;
        tick();
        tick();
        bus.mul_send_val = 1'b0;
        chk("s_resp_val", 32'(bus.resp_val), 32'h1);
        chk("s_resp_c", bus.resp_c, 32'hFFFE_0000);
        bus.resp_rdy = 4'b0001;
        tick();
        bus.resp_rdy = '0;
        chk("s_done_busy", 32'(bus.busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fixed_point_mult_arbiter.md
FIXED_POINT_MULT_ARBITER -- requirements
Module: fixed_point_mult_arbiter

Interface
REQ-001 The block SHALL have parameter n, default 32, meaning operand/result bit width.
REQ-002 The block SHALL have parameter d, default 16, meaning fractional bit count; it is passed through to the shared multiplier only.
REQ-003 The block SHALL have parameter NREQ, default 4 (range 1-8), meaning number of requesters.
REQ-004 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; one clock; reset is synchronous and active-low.
- reset_n  in  1  synchronous active-low reset.
- req_val  in  NREQ  per-requester operand valid.
- req_rdy  out  NREQ  per-requester operand ready.
- req_a  in  NREQ*n  packed operand a; requester i occupies bits [i*n +: n].
- req_b  in  NREQ*n  packed operand b; same packing as req_a.
- resp_val  out  NREQ  per-requester result valid.
- resp_rdy  in  NREQ  per-requester result ready.
- resp_c  out  n  result, shared by all requesters.
- mul_recv_val  out  1  to the multiplier's recv_val.
- mul_recv_rdy  in  1  from the multiplier's recv_rdy.
- mul_a  out  n  to multiplier operand a.
- mul_b  out  n  to multiplier operand b.
- mul_send_val  in  1  from the multiplier's send_val.
- mul_send_rdy  out  1  to the multiplier's send_rdy.
- mul_c  in  n  from the multiplier's result c.
- grant_id  out  clog2(NREQ) (min 1)  index of the owning requester.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-006 In IDLE, when any req_val bit is set, the block SHALL select a winner by round-robin from pointer rr_ptr:
- Search order is rr_ptr, rr_ptr+1, ... modulo NREQ.
- req_rdy[winner] SHALL be 1 in that same cycle (combinational); all other req_rdy bits SHALL be 0.
REQ-007 On the accept cycle (IDLE, req_val[w] and req_rdy[w] both high), the block SHALL:
- register req_a[w], req_b[w] and w;
- set rr_ptr to (w+1) mod NREQ;
- go to ISSUE.
REQ-008 In ISSUE, mul_recv_val SHALL be 1 with mul_a/mul_b driven from the registered operands; when mul_recv_rdy is 1 the FSM SHALL go to WAIT, otherwise it SHALL stay in ISSUE.
REQ-009 In WAIT, mul_send_rdy SHALL be 1. On mul_send_val=1 the block SHALL register mul_c into the result register and go to RESP.
REQ-010 In RESP, resp_val[grant_id] SHALL be 1 and resp_c SHALL equal the result register. On resp_rdy[grant_id]=1 the FSM SHALL go to IDLE.
REQ-011 Outside their respective states, req_rdy, resp_val, mul_recv_val and mul_send_rdy SHALL be 0. mul_a/mul_b SHALL hold the registered operands at all times.
REQ-012 Arbiter overhead latency SHALL be:
- one cycle from accept to mul_recv_val;
- one cycle from the multiplier's send handshake to resp_val.
REQ-013 Only one transaction SHALL be outstanding at a time. req_val asserted in ISSUE/WAIT/RESP SHALL be held off (req_rdy=0) until IDLE.
REQ-014 A requester deasserting req_val before it is granted SHALL cause no state change. resp_rdy bits of non-owning requesters SHALL be ignored.
REQ-015 resp_c and resp_val SHALL remain stable during RESP backpressure. No new grant SHALL occur until the response handshake completes.
REQ-016 A requester re-asserting req_val immediately after its response SHALL NOT be granted again while any other requester is valid (fairness follows from REQ-007).
REQ-017 With NREQ=1, the block SHALL degenerate to a pass-through sequencer with grant_id always 0.
REQ-018 The block SHALL perform no arithmetic on operands or results. Sign and fixed-point handling are the multiplier's responsibility.

Reset
REQ-019 When reset_n=0 at a clk edge, the block SHALL, regardless of state (including mid-ISSUE/WAIT/RESP):
- go to IDLE;
- set rr_ptr=0, grant_id=0;
- set the operand and result registers to 0.
REQ-020 During and immediately after reset, all outputs SHALL be 0: req_rdy, resp_val, resp_c, mul_recv_val, mul_send_rdy, mul_a, mul_b, grant_id, busy. Any in-flight transaction SHALL be dropped without a response.
REQ-021 The integrator SHALL drive the multiplier's active-high reset from !reset_n so both blocks reset in the same cycle.

Verification
REQ-022 Scenario: n=32, d=16, unsigned; requester 2 sends a=0x00020000, b=0x00018000 -> resp_val[2] only, resp_c=0x00030000, grant_id=2.
REQ-023 Scenario: signed multiplier; requester 0 sends a=0xFFFF0000, b=0x00020000 -> resp_c=0xFFFE0000.
REQ-024 Scenario: all four req_val held high from reset with resp_rdy=all ones -> grant order 0,1,2,3,0,1.
REQ-025 Scenario: resp_rdy[1] held low 5 cycles while requester 3 is valid -> resp_val[1] and resp_c stable for 5 cycles, req_rdy[3]=0 throughout, requester 3 granted in the first IDLE cycle after the handshake.
REQ-026 Scenario: mul_recv_rdy held low 3 cycles -> FSM stays in ISSUE with mul_recv_val=1 and operands stable.
REQ-027 Scenario: reset_n pulsed low while in WAIT -> all outputs 0 the next cycle, no resp_val for the dropped operation, and the next accepted request granted starting from requester 0.
